// File: rtl/crc32_pkg.sv
// crc32_pkg: CRC-32 constants, FSM encoding and the bytewise reflected update
package crc32_pkg;
    localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC_POLY : c >> 1;
        return c;
    endfunction
endpackage

// File: rtl/crc32_word_update.sv
// crc32_word_update: folds the 1, 2 or 4 low lanes of a word into a CRC, lane [7:0] first
module crc32_word_update
    import crc32_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data,
    input  logic [2:0]  nbytes,
    output logic [31:0] crc_next
);
    logic [31:0] b0, b1, b2, b3;
    assign b0 = crc32_byte(crc_in, data[7:0]);
    assign b1 = crc32_byte(b0, data[15:8]);
    assign b2 = crc32_byte(b1, data[23:16]);
    assign b3 = crc32_byte(b2, data[31:24]);
    assign crc_next = nbytes == 3'd4 ? b3 : nbytes == 3'd2 ? b1 : b0;
endmodule

// File: rtl/crc32_stream_engine.sv
// crc32_stream_engine: CRC-32 over total_len bytes popped from the read-data FIFO
module crc32_stream_engine
    import crc32_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  total_len,
    input  logic                  abort,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           crc_out
);
    localparam int CW = LEN_WIDTH - 1;
    state_t        state;
    logic [CW-1:0] full_words, words_total, issued, consumed;
    logic          has_half, rd_vld;
    logic [2:0]    rd_nb, nb;
    logic [31:0]   crc_acc, crc_next;
    assign fifo_rd_en = state == RUN && !fifo_empty && issued < words_total;
    assign nb = issued < full_words ? 3'd4 : (issued == full_words && has_half) ? 3'd2 : 3'd1;
    crc32_word_update u_upd (
        .crc_in  (crc_acc),
        .data    (fifo_rdata[31:0]),
        .nbytes  (rd_nb),
        .crc_next(crc_next)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            full_words  <= '0;
            has_half    <= 1'b0;
            words_total <= '0;
            issued      <= '0;
            consumed    <= '0;
            rd_vld      <= 1'b0;
            rd_nb       <= '0;
            crc_acc     <= CRC_INIT;
            crc_out     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done   <= 1'b0;
            rd_vld <= fifo_rd_en;
            rd_nb  <= nb;
            if (fifo_rd_en) issued <= issued + 1'b1;
            if (abort) begin
                state  <= IDLE;
                busy   <= 1'b0;
                rd_vld <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        full_words  <= CW'(total_len[LEN_WIDTH-1:2]);
                        has_half    <= total_len[1];
                        words_total <= CW'(total_len[LEN_WIDTH-1:2]) + CW'(total_len[1]) + CW'(total_len[0]);
                        issued      <= '0;
                        consumed    <= '0;
                        crc_acc     <= CRC_INIT;
                        busy        <= 1'b1;
                        state       <= total_len == '0 ? FINISH : RUN;
                    end
                    RUN: if (rd_vld) begin
                        crc_acc  <= crc_next;
                        consumed <= consumed + 1'b1;
                        // the last word finishes here so done lands in the first FINISH cycle
                        if (consumed + 1'b1 == words_total) begin
                            state   <= FINISH;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            crc_out <= crc_next ^ CRC_XOROUT;
                        end
                    end
                    FINISH: if (!done) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        crc_out <= crc_acc ^ CRC_XOROUT;
                    end else state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
